// File: rtl/pipe_pkg.sv
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared types and per-stage widths for the elastic pipeline registers
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_t;

    localparam int IF_ID_CTRL_W = 3;
    localparam int ID_IE_CTRL_W = 3;
    localparam int IE_IM_CTRL_W = 3;
    localparam int IM_WB_CTRL_W = 3;
    localparam int PIPE_DATA_W  = 105;
    localparam int PIPE_CTRL_W  = 3;

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// ============================================================================
//  Module   : pipe_slot
//  Purpose  : One valid + payload + control register with load/clear controls
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_slot #(
    parameter int DATA_W = 105,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    // Clear only drops the valid bit; payload is left as a don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Elastic valid/ready pipeline-stage register with flush and optional skid entry
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 105,
    parameter int CTRL_W = 3,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    pipe_state_t       r_state;
    pipe_state_t       w_next_state;
    logic              w_accept;
    logic              w_consume;
    logic              w_main_load;
    logic              w_main_clear;
    logic              w_main_valid;
    logic [DATA_W-1:0] w_main_data;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_din;
    logic [CTRL_W-1:0] w_main_cin;
    logic              w_skid_valid;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_skid_ctrl;

    assign w_accept  = in_valid & in_ready;
    assign w_consume = w_main_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PS_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = PS_EMPTY;
        end else begin
            case (r_state)
                PS_EMPTY: if (w_accept) w_next_state = PS_ONE;
                PS_ONE: begin
                    if (w_accept && !w_consume) begin
                        w_next_state = (SKID != 0) ? PS_FULL : PS_ONE;
                    end else if (!w_accept && w_consume) begin
                        w_next_state = PS_EMPTY;
                    end
                end
                PS_FULL:  if (w_consume) w_next_state = PS_ONE;
                default:  w_next_state = PS_EMPTY;
            endcase
        end
    end

    // With a skid entry in_ready comes from flops only; without one it looks through to out_ready.
    always_comb begin
        in_ready  = 1'b1;
        occupancy = 2'd0;
        case (r_state)
            PS_EMPTY: occupancy = 2'd0;
            PS_ONE:   occupancy = 2'd1;
            PS_FULL:  occupancy = 2'd2;
            default:  occupancy = 2'd0;
        endcase
        if (SKID != 0) begin
            in_ready = (r_state != PS_FULL);
        end else begin
            in_ready = (r_state == PS_EMPTY) | out_ready;
        end
    end

    assign w_main_load  = ((r_state == PS_EMPTY) & w_accept)
                        | ((r_state == PS_ONE)   & w_accept & w_consume)
                        | ((r_state == PS_FULL)  & w_consume);
    assign w_main_clear = flush | (w_consume & ~w_main_load);

    // The skid entry, when present, is always older than the input port.
    assign w_main_din = w_skid_valid ? w_skid_data : in_data;
    assign w_main_cin = w_skid_valid ? w_skid_ctrl : in_ctrl;

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_din),
        .i_ctrl  (w_main_cin),
        .o_valid (w_main_valid),
        .o_data  (w_main_data),
        .o_ctrl  (w_main_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic w_skid_load;
            logic w_skid_clear;

            assign w_skid_load  = (r_state == PS_ONE) & w_accept & ~w_consume;
            assign w_skid_clear = flush | ((r_state == PS_FULL) & w_consume);

            pipe_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clear),
                .i_data  (in_data),
                .i_ctrl  (in_ctrl),
                .o_valid (w_skid_valid),
                .o_data  (w_skid_data),
                .o_ctrl  (w_skid_ctrl)
            );
        end else begin : g_no_skid
            assign w_skid_valid = 1'b0;
            assign w_skid_data  = '0;
            assign w_skid_ctrl  = '0;
        end
    endgenerate

    assign out_valid = w_main_valid;
    assign out_data  = w_main_data;
    assign out_ctrl  = w_main_ctrl & {CTRL_W{w_main_valid}};

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Purpose  : Self-checking bench for pipe_stage_reg, skid and no-skid builds
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    localparam int DW = 105;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // a_* : skid build, b_* : single-entry build
    logic          a_fl, a_iv, a_ir, a_ov, a_or;
    logic [DW-1:0] a_id, a_od;
    logic [CW-1:0] a_ic, a_oc;
    logic [1:0]    a_occ;
    logic          b_fl, b_iv, b_ir, b_ov, b_or;
    logic [DW-1:0] b_id, b_od;
    logic [CW-1:0] b_ic, b_oc;
    logic [1:0]    b_occ;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir),
        .in_data(a_id), .in_ctrl(a_ic), .out_valid(a_ov), .out_ready(a_or),
        .out_data(a_od), .out_ctrl(a_oc), .occupancy(a_occ)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_fl), .in_valid(b_iv), .in_ready(b_ir),
        .in_data(b_id), .in_ctrl(b_ic), .out_valid(b_ov), .out_ready(b_or),
        .out_data(b_od), .out_ctrl(b_oc), .occupancy(b_occ)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit         iv;
        bit         ordy;
        bit         fl;
        logic [7:0] d;
        logic [2:0] c;
        bit         chk_d;
        bit         e_ov;
        logic [7:0] e_od;
        logic [2:0] e_oc;
        logic [1:0] e_occ;
        bit         e_ir;
    } vec_t;

    vec_t tv[$];

    // Reference model: ordered list of held entries per build (index 0 = no skid, 1 = skid)
    logic [DW-1:0] md[2][2];
    logic [CW-1:0] mc[2][2];
    int            mn[2];

    initial begin
        logic [127:0] rnd;
        bit           acc[2];
        bit           con[2];
        bit           exp_ir;
        bit           r_iv, r_or, r_fl;
        logic [DW-1:0] r_d;
        logic [CW-1:0] r_c;

        {a_fl, a_iv, a_or, a_id, a_ic} = '0;
        {b_fl, b_iv, b_or, b_id, b_ic} = '0;

        #2;
        chk("reset a_out_valid", a_ov, 0);
        chk("reset a_out_data", a_od, 0);
        chk("reset a_out_ctrl", a_oc, 0);
        chk("reset a_occupancy", a_occ, 0);
        chk("reset a_in_ready", a_ir, 1);
        chk("reset b_occupancy", b_occ, 0);
        #10 rst_n = 1'b1;

        //           iv ordy fl  d      c     chkd ov  od     oc    occ ir
        tv.push_back('{1, 1, 0, 8'h11, 3'd1, 1, 1, 8'h11, 3'd1, 2'd1, 1});
        tv.push_back('{1, 1, 0, 8'h12, 3'd2, 1, 1, 8'h12, 3'd2, 2'd1, 1});
        tv.push_back('{1, 1, 0, 8'h13, 3'd3, 1, 1, 8'h13, 3'd3, 2'd1, 1});
        tv.push_back('{1, 1, 0, 8'h14, 3'd4, 1, 1, 8'h14, 3'd4, 2'd1, 1});
        tv.push_back('{0, 1, 0, 8'h99, 3'd5, 0, 0, 8'h00, 3'd0, 2'd0, 1});
        tv.push_back('{1, 1, 0, 8'h15, 3'd5, 1, 1, 8'h15, 3'd5, 2'd1, 1});
        tv.push_back('{0, 1, 0, 8'h00, 3'd0, 0, 0, 8'h00, 3'd0, 2'd0, 1});
        tv.push_back('{1, 0, 0, 8'h0A, 3'd2, 1, 1, 8'h0A, 3'd2, 2'd1, 1});
        tv.push_back('{1, 0, 0, 8'h0B, 3'd3, 1, 1, 8'h0A, 3'd2, 2'd2, 0});
        tv.push_back('{1, 0, 0, 8'h0C, 3'd4, 1, 1, 8'h0A, 3'd2, 2'd2, 0});
        tv.push_back('{1, 1, 0, 8'h0C, 3'd4, 1, 1, 8'h0B, 3'd3, 2'd1, 1});
        tv.push_back('{1, 1, 0, 8'h0C, 3'd4, 1, 1, 8'h0C, 3'd4, 2'd1, 1});
        tv.push_back('{0, 1, 0, 8'h00, 3'd0, 0, 0, 8'h00, 3'd0, 2'd0, 1});
        tv.push_back('{1, 0, 0, 8'h21, 3'd7, 1, 1, 8'h21, 3'd7, 2'd1, 1});
        tv.push_back('{1, 0, 0, 8'h22, 3'd7, 1, 1, 8'h21, 3'd7, 2'd2, 0});
        tv.push_back('{1, 0, 1, 8'h23, 3'd7, 0, 0, 8'h00, 3'd0, 2'd0, 1});
        tv.push_back('{1, 1, 1, 8'h24, 3'd7, 0, 0, 8'h00, 3'd0, 2'd0, 1});
        tv.push_back('{1, 1, 0, 8'h25, 3'd6, 1, 1, 8'h25, 3'd6, 2'd1, 1});
        tv.push_back('{1, 0, 0, 8'h26, 3'd1, 1, 1, 8'h25, 3'd6, 2'd2, 0});

        @(posedge clk); #1;
        foreach (tv[i]) begin
            a_iv = tv[i].iv;
            a_or = tv[i].ordy;
            a_fl = tv[i].fl;
            a_id = DW'(tv[i].d);
            a_ic = tv[i].c;
            @(posedge clk); #1;
            chk($sformatf("vec%0d out_valid", i), a_ov, tv[i].e_ov);
            chk($sformatf("vec%0d out_ctrl", i), a_oc, tv[i].e_oc);
            chk($sformatf("vec%0d occupancy", i), a_occ, tv[i].e_occ);
            chk($sformatf("vec%0d in_ready", i), a_ir, tv[i].e_ir);
            if (tv[i].chk_d) chk($sformatf("vec%0d out_data", i), a_od, DW'(tv[i].e_od));
        end
        a_fl = 1'b0;

        // Asynchronous reset while FULL, between edges
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", a_ov, 0);
        chk("async rst out_ctrl", a_oc, 0);
        chk("async rst occupancy", a_occ, 0);
        chk("async rst out_data", a_od, 0);
        chk("async rst in_ready", a_ir, 1);
        a_iv = 1'b1; a_id = DW'(8'h30); a_ic = 3'd5;
        @(posedge clk); #1;
        chk("no capture in reset", a_occ, 0);
        rst_n = 1'b1;
        a_id = DW'(8'h31); a_ic = 3'd2; a_or = 1'b0;
        @(posedge clk); #1;
        chk("post-reset out_data", a_od, DW'(8'h31));
        chk("post-reset occupancy", a_occ, 1);
        chk("post-reset out_ctrl", a_oc, 3'd2);
        a_iv = 1'b0;

        // Single-entry build: combinational ready path
        b_iv = 1'b1; b_id = DW'(8'h41); b_ic = 3'd3; b_or = 1'b0;
        #1 chk("noskid empty in_ready", b_ir, 1);
        @(posedge clk); #1;
        chk("noskid out_data", b_od, DW'(8'h41));
        chk("noskid occupancy", b_occ, 1);
        b_id = DW'(8'h42);
        #1 chk("noskid stall in_ready", b_ir, 0);
        b_or = 1'b1;
        #1 chk("noskid ready passthru", b_ir, 1);
        @(posedge clk); #1;
        chk("noskid acc+con data", b_od, DW'(8'h42));
        chk("noskid acc+con occ", b_occ, 1);
        b_iv = 1'b0;
        @(posedge clk); #1;
        chk("noskid drained", b_ov, 0);

        // Randomised run, both builds on identical inputs against the queue model
        rst_n = 1'b0;
        {a_fl, a_iv, a_or} = '0;
        {b_fl, b_iv, b_or} = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mn[0] = 0;
        mn[1] = 0;
        for (int n = 0; n < 400; n++) begin
            rnd  = {$urandom, $urandom, $urandom, $urandom};
            r_d  = rnd[DW-1:0];
            r_c  = CW'($urandom_range(0, 7));
            r_iv = ($urandom_range(0, 3) != 0);
            r_or = ($urandom_range(0, 2) != 0);
            r_fl = ($urandom_range(0, 15) == 0);
            a_iv = r_iv; a_or = r_or; a_fl = r_fl; a_id = r_d; a_ic = r_c;
            b_iv = r_iv; b_or = r_or; b_fl = r_fl; b_id = r_d; b_ic = r_c;
            #1;
            for (int k = 0; k < 2; k++) begin
                exp_ir = (k == 1) ? (mn[k] < 2) : (mn[k] == 0 || r_or);
                chk($sformatf("rnd%0d b%0d in_ready", n, k), (k == 1) ? a_ir : b_ir, exp_ir);
                acc[k] = r_iv && exp_ir;
                con[k] = (mn[k] > 0) && r_or;
            end
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (r_fl) begin
                    mn[k] = 0;
                end else begin
                    if (con[k]) begin
                        md[k][0] = md[k][1];
                        mc[k][0] = mc[k][1];
                        mn[k]--;
                    end
                    if (acc[k]) begin
                        md[k][mn[k]] = r_d;
                        mc[k][mn[k]] = r_c;
                        mn[k]++;
                    end
                end
                chk($sformatf("rnd%0d b%0d out_valid", n, k), (k == 1) ? a_ov : b_ov, mn[k] > 0);
                chk($sformatf("rnd%0d b%0d occupancy", n, k), (k == 1) ? a_occ : b_occ, mn[k]);
                chk($sformatf("rnd%0d b%0d out_ctrl", n, k), (k == 1) ? a_oc : b_oc,
                    (mn[k] > 0) ? mc[k][0] : 3'd0);
                if (mn[k] > 0)
                    chk($sformatf("rnd%0d b%0d out_data", n, k), (k == 1) ? a_od : b_od, md[k][0]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
